// File: rtl/microwave_pkg.sv
// Shared constants for the microwave control/display core: seven-segment
// patterns (active-high, bit6=a .. bit0=g) and BCD digit limits.
package microwave_pkg;

    localparam logic [6:0] SEG_0     = 7'h7E;
    localparam logic [6:0] SEG_1     = 7'h30;
    localparam logic [6:0] SEG_2     = 7'h6D;
    localparam logic [6:0] SEG_3     = 7'h79;
    localparam logic [6:0] SEG_4     = 7'h33;
    localparam logic [6:0] SEG_5     = 7'h5B;
    localparam logic [6:0] SEG_6     = 7'h5F;
    localparam logic [6:0] SEG_7     = 7'h70;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h7B;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Largest value each timer digit takes on a borrow / may be loaded with.
    localparam logic [3:0] ONES_MAX = 4'd9;
    localparam logic [3:0] TENS_MAX = 4'd5;
    localparam logic [3:0] MIN_MAX  = 4'd9;

endpackage

// File: rtl/microwave_core_seg7_decoder.sv
// BCD to seven-segment decoder. Non-decimal codes (10-15) blank the digit.
module seg7_decoder
    import microwave_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_segs
);

    // Pure lookup from digit value to segment pattern.
    always_comb begin
        o_segs = SEG_BLANK;
        case (i_bcd)
            4'd0:    o_segs = SEG_0;
            4'd1:    o_segs = SEG_1;
            4'd2:    o_segs = SEG_2;
            4'd3:    o_segs = SEG_3;
            4'd4:    o_segs = SEG_4;
            4'd5:    o_segs = SEG_5;
            4'd6:    o_segs = SEG_6;
            4'd7:    o_segs = SEG_7;
            4'd8:    o_segs = SEG_8;
            4'd9:    o_segs = SEG_9;
            default: o_segs = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/microwave_core.sv
// Microwave control/display core: magnetron on/off latch, M:SS BCD countdown
// timer loaded by shifting keypad digits in from the right, and three
// seven-segment displays.
//
// Strobes: digit_load and sec_tick are single-cycle enables sampled on the
// rising clock edge; there is no back-pressure, an ignored strobe is lost.
module microwave_core
    import microwave_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       startn,
    input  logic       stopn,
    input  logic       clearn,
    input  logic       door_closed,
    input  logic [3:0] digit_in,
    input  logic       digit_load,
    input  logic       sec_tick,
    output logic       mag_on,
    output logic       zero,
    output logic [3:0] min_digit,
    output logic [3:0] tens_digit,
    output logic [3:0] ones_digit,
    output logic [6:0] min_segs,
    output logic [6:0] sec_tens_segs,
    output logic [6:0] sec_ones_segs
);

    logic       r_mag_on;
    logic [3:0] r_min;
    logic [3:0] r_tens;
    logic [3:0] r_ones;

    logic       w_zero;
    logic       w_mag_next;
    logic [3:0] w_min_next;
    logic [3:0] w_tens_next;
    logic [3:0] w_ones_next;

    assign w_zero = (r_min == 4'd0) && (r_tens == 4'd0) && (r_ones == 4'd0);

    // Magnetron latch: any stop condition beats start; start needs a closed
    // door and time on the clock (zero blocks it via the clear term).
    always_comb begin
        w_mag_next = r_mag_on;
        if (!clearn || !stopn || !door_closed || w_zero) begin
            w_mag_next = 1'b0;
        end else if (!startn) begin
            w_mag_next = 1'b1;
        end
    end

    // Timer next value: clear, then keypad shift (only while idle), then a
    // one-second BCD decrement (only while cooking and not already at 0:00).
    always_comb begin
        w_min_next  = r_min;
        w_tens_next = r_tens;
        w_ones_next = r_ones;
        if (!clearn) begin
            w_min_next  = 4'd0;
            w_tens_next = 4'd0;
            w_ones_next = 4'd0;
        end else if (digit_load && !r_mag_on && (digit_in <= MIN_MAX)) begin
            w_min_next  = r_tens;
            w_tens_next = r_ones;
            w_ones_next = digit_in;
        end else if (sec_tick && r_mag_on && !w_zero) begin
            if (r_ones != 4'd0) begin
                w_ones_next = r_ones - 4'd1;
            end else begin
                w_ones_next = ONES_MAX;
                if (r_tens != 4'd0) begin
                    w_tens_next = r_tens - 4'd1;
                end else begin
                    // Tens 6-9 entered by hand just count down; a full
                    // borrow always wraps seconds to 59.
                    w_tens_next = TENS_MAX;
                    w_min_next  = r_min - 4'd1;
                end
            end
        end
    end

    // State registers with synchronous reset to 0:00, magnetron off.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_mag_on <= 1'b0;
            r_min    <= 4'd0;
            r_tens   <= 4'd0;
            r_ones   <= 4'd0;
        end else begin
            r_mag_on <= w_mag_next;
            r_min    <= w_min_next;
            r_tens   <= w_tens_next;
            r_ones   <= w_ones_next;
        end
    end

    assign mag_on     = r_mag_on;
    assign zero       = w_zero;
    assign min_digit  = r_min;
    assign tens_digit = r_tens;
    assign ones_digit = r_ones;

    seg7_decoder u_min_dec (
        .i_bcd  (r_min),
        .o_segs (min_segs)
    );

    seg7_decoder u_tens_dec (
        .i_bcd  (r_tens),
        .o_segs (sec_tens_segs)
    );

    seg7_decoder u_ones_dec (
        .i_bcd  (r_ones),
        .o_segs (sec_ones_segs)
    );

endmodule

// File: tb/tb_microwave_core.sv
// Self-checking bench for microwave_core. The reference keeps the displayed
// time as one decimal number 0..999 (M:SS read as digits) and the magnetron
// as a bit; loading is "append a digit, keep three", ticking is
// "subtract one second, wrapping :00 to :59 of the previous minute".
module tb_microwave_core;

    logic       clock;
    logic       reset;
    logic       startn;
    logic       stopn;
    logic       clearn;
    logic       door_closed;
    logic [3:0] digit_in;
    logic       digit_load;
    logic       sec_tick;
    logic       mag_on;
    logic       zero;
    logic [3:0] min_digit;
    logic [3:0] tens_digit;
    logic [3:0] ones_digit;
    logic [6:0] min_segs;
    logic [6:0] sec_tens_segs;
    logic [6:0] sec_ones_segs;

    int err_cnt;
    int chk_cnt;

    // Reference state.
    int   m_val;
    logic m_mag;

    logic [6:0] seg_tab [16];

    microwave_core dut (
        .clock         (clock),
        .reset         (reset),
        .startn        (startn),
        .stopn         (stopn),
        .clearn        (clearn),
        .door_closed   (door_closed),
        .digit_in      (digit_in),
        .digit_load    (digit_load),
        .sec_tick      (sec_tick),
        .mag_on        (mag_on),
        .zero          (zero),
        .min_digit     (min_digit),
        .tens_digit    (tens_digit),
        .ones_digit    (ones_digit),
        .min_segs      (min_segs),
        .sec_tens_segs (sec_tens_segs),
        .sec_ones_segs (sec_ones_segs)
    );

    // Clock generation.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic compare_all();
        logic [11:0] b;
        b = to_bcd(m_val);
        check("mag_on", {31'd0, mag_on}, {31'd0, m_mag});
        check("zero", {31'd0, zero}, {31'd0, (m_val == 0)});
        check("digits", {20'd0, min_digit, tens_digit, ones_digit}, {20'd0, b});
        check("segs", {11'd0, min_segs, sec_tens_segs, sec_ones_segs},
              {11'd0, seg_tab[b[11:8]], seg_tab[b[7:4]], seg_tab[b[3:0]]});
    endtask

    // Drive one cycle of inputs, advance the reference, then compare after
    // the edge has settled.
    task automatic step(input logic rst, input logic st, input logic sp, input logic cl,
                        input logic dr, input logic ld, input logic [3:0] din, input logic tk);
        int   nv;
        logic nm;
        logic z;
        reset = rst; startn = st; stopn = sp; clearn = cl;
        door_closed = dr; digit_load = ld; digit_in = din; sec_tick = tk;
        z  = (m_val == 0);
        nm = m_mag;
        if (rst) nm = 1'b0;
        else if (!cl || !sp || !dr || z) nm = 1'b0;
        else if (!st) nm = 1'b1;
        nv = m_val;
        if (rst || !cl) nv = 0;
        else if (ld && !m_mag && din <= 4'd9) nv = (m_val * 10 + int'(din)) % 1000;
        else if (tk && m_mag && !z) nv = (m_val % 100 != 0) ? m_val - 1 : m_val - 100 + 59;
        @(posedge clock);
        m_val = nv;
        m_mag = nm;
        #1;
        compare_all();
    endtask

    task automatic idle();           step(0, 1, 1, 1, 1, 0, 4'd0, 0); endtask
    task automatic press_start();    step(0, 0, 1, 1, 1, 0, 4'd0, 0); endtask
    task automatic press_stop();     step(0, 1, 0, 1, 1, 0, 4'd0, 0); endtask
    task automatic press_clear();    step(0, 1, 1, 0, 1, 0, 4'd0, 0); endtask
    task automatic tick();           step(0, 1, 1, 1, 1, 0, 4'd0, 1); endtask
    task automatic load(input logic [3:0] d); step(0, 1, 1, 1, 1, 1, d, 0); endtask

    task automatic check_time(input string tag, input logic [11:0] bcd);
        check(tag, {20'd0, min_digit, tens_digit, ones_digit}, {20'd0, bcd});
    endtask

    initial begin
        err_cnt = 0;
        chk_cnt = 0;
        m_val   = 0;
        m_mag   = 1'b0;
        seg_tab = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                    7'h7F, 7'h7B, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
        reset = 1'b1; startn = 1'b1; stopn = 1'b1; clearn = 1'b1;
        door_closed = 1'b1; digit_in = 4'd0; digit_load = 1'b0; sec_tick = 1'b0;

        // Reset state.
        step(1, 1, 1, 1, 1, 0, 4'd0, 0);
        step(1, 1, 1, 1, 1, 0, 4'd0, 0);
        check("rst_mag", {31'd0, mag_on}, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd1);
        check_time("rst_time", 12'h000);
        check("rst_segs", {11'd0, min_segs, sec_tens_segs, sec_ones_segs}, {11'd0, 7'h7E, 7'h7E, 7'h7E});

        // Load 1,3,0 -> 1:30.
        load(4'd1); load(4'd3); load(4'd0);
        check_time("load_130", 12'h130);
        check("segs_130", {11'd0, min_segs, sec_tens_segs, sec_ones_segs}, {11'd0, 7'h30, 7'h79, 7'h7E});
        check("zero_130", {31'd0, zero}, 32'd0);
        check("mag_130", {31'd0, mag_on}, 32'd0);

        // 0:02 countdown to termination.
        press_clear(); load(4'd0); load(4'd2);
        press_start();
        check("start_mag", {31'd0, mag_on}, 32'd1);
        tick(); check_time("cd_001", 12'h001);
        tick(); check_time("cd_000", 12'h000);
        check("cd_zero", {31'd0, zero}, 32'd1);
        check("cd_mag_last", {31'd0, mag_on}, 32'd1);
        idle(); check("cd_mag_off", {31'd0, mag_on}, 32'd0);

        // Borrow chains.
        press_clear(); load(4'd1); load(4'd0); load(4'd0);
        press_start(); tick(); check_time("borrow_059", 12'h059);
        press_clear(); load(4'd1); load(4'd0);
        press_start(); tick(); check_time("borrow_009", 12'h009);
        press_clear(); load(4'd0); load(4'd7); load(4'd0);
        press_start(); tick(); check_time("tens7_069", 12'h069);

        // Door opens mid-cook: pause, then resume.
        press_clear(); load(4'd4); load(4'd5); press_start();
        step(0, 1, 1, 1, 0, 0, 4'd0, 0);
        check("door_mag", {31'd0, mag_on}, 32'd0);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 0, 0, 4'd0, 1);
        check_time("door_hold", 12'h045);
        press_start(); check("resume_mag", {31'd0, mag_on}, 32'd1);
        tick(); check_time("resume_044", 12'h044);

        // Precedence.
        press_clear(); load(4'd1); load(4'd0);
        step(0, 0, 0, 1, 1, 0, 4'd0, 0);
        check("start_stop", {31'd0, mag_on}, 32'd0);
        press_start(); load(4'd7); check_time("load_cooking", 12'h010);
        press_stop(); load(4'd12); check_time("load_12", 12'h010);
        press_clear(); load(4'd2); load(4'd1); load(4'd5); press_start();
        press_clear();
        check("clear_mag", {31'd0, mag_on}, 32'd0);
        check_time("clear_time", 12'h000);
        press_start(); check("start_zero", {31'd0, mag_on}, 32'd0);
        load(4'd3); load(4'd0); press_start(); tick();
        step(1, 1, 1, 1, 1, 0, 4'd0, 0);
        check("rst_mid_mag", {31'd0, mag_on}, 32'd0);
        check_time("rst_mid_time", 12'h000);

        // Randomized traffic against the reference.
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 29) != 0),
                 ($urandom_range(0, 99) != 0),
                 ($urandom_range(0, 19) != 0),
                 ($urandom_range(0, 2) == 0),
                 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 1) == 1));
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/microwave_core.md
Name: microwave_core

Overview:
- Control-and-display core of the microwave oven: magnetron on/off latch, 3-digit BCD countdown timer (M:SS), and three 7-segment decoders.
- Keypad encoding and the 1 Hz tick generator live upstream. This block receives an already-encoded digit strobe and a one-cycle seconds tick, all synchronous to one clock.

Parameters:
- None.

Ports:
- clock  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- startn  input  1  start button, active-low level
- stopn  input  1  stop/pause button, active-low level
- clearn  input  1  clear button, active-low level; stops cooking and zeroes time
- door_closed  input  1  1 = door closed
- digit_in  input  4  BCD digit from keypad encoder
- digit_load  input  1  one-cycle strobe: shift digit_in into timer
- sec_tick  input  1  one-cycle enable, once per second
- mag_on  output  1  magnetron enable (registered)
- zero  output  1  timer reads 0:00 (combinational from timer registers)
- min_digit, tens_digit, ones_digit  output  4 each  BCD timer value
- min_segs, sec_tens_segs, sec_ones_segs  output  7 each  segments, active-high, bit6=a … bit0=g

Behaviour:
- Reset: mag_on=0 and all digits=0, so zero=1 and all three displays show "0".
- Magnetron latch priority, per clock edge:
  1. reset
  2. clear to 0 if clearn=0, stopn=0, door_closed=0, or zero=1
  3. set to 1 if startn=0, door_closed=1 and zero=0
  4. otherwise hold
- Consequences of that priority:
  - start held together with stop or clear gives mag_on=0.
  - Start with 0:00 on the timer has no effect.
  - Opening the door mid-cook clears mag_on on the next edge; the timer holds its value (pause).
- Timer priority, per clock edge:
  1. reset → 0:00
  2. clearn=0 → 0:00
  3. digit_load=1 and mag_on=0 and digit_in≤9 → min←tens, tens←ones, ones←digit_in (old min discarded)
  4. sec_tick=1 and mag_on=1 and zero=0 → BCD decrement
  5. hold
- Loading rules:
  - digit_load while mag_on=1 is ignored.
  - digit_in>9 is ignored.
  - A tens value 6–9 may be entered by shifting and is held as-is.
- BCD decrement:
  - ones>0: ones−1.
  - Else ones=9 and borrow from tens: tens>0 gives tens−1; else tens=5 and min−1.
  - Never underflows, since decrement is gated by zero=0.
- Termination: the tick that brings the value to 0:00 makes zero=1, and mag_on clears on the following edge. Exactly one cycle with mag_on=1 and zero=1.
- Decoder: combinational. Segment patterns a..g:
  - 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70, 8=7F, 9=7B (hex)
  - Values 10–15 → 00 (blank)
- Latency:
  - Buttons to mag_on: 1 cycle.
  - sec_tick to digits: 1 cycle.
  - Digits to segments: 0 cycles.

Decomposition:
- Shared package microwave_pkg: the ten segment constants, SEG_BLANK, BCD max constants (ONES_MAX=9, TENS_MAX=5, MIN_MAX=9).
- One sub-module seg7_decoder (4-bit BCD in, 7-bit segs out), instantiated three times.
- Magnetron latch and countdown logic stay inline in microwave_core.

Test Plan:
- Reset, then load digits 1,3,0 → digits 1:30; min_segs=30, sec_tens_segs=79, sec_ones_segs=7E; zero=0; mag_on=0.
- From 0:02, startn low one cycle with door_closed=1 → mag_on=1 next edge; sec_tick ×2 → 0:01 then 0:00, zero=1; mag_on=0 one edge later.
- Borrow chain from 1:00 with mag_on=1, one sec_tick → 0:59. From 0:10, one tick → 0:09.
- Door opens at 0:45 mid-cook → mag_on=0 next edge; sec_ticks leave 0:45. Close the door and press start → resumes.
- Precedence checks:
  - startn and stopn low together → mag_on stays 0.
  - clearn low while cooking at 2:15 → mag_on=0 and 0:00 next edge.
  - digit_load during cooking → value unchanged.
  - digit_in=12 → ignored.
- Start with timer 0:00 → mag_on stays 0. reset asserted mid-cook → mag_on=0 and 0:00 next edge.
